// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring integer divider, one quotient bit per clock.
// Signed operands are reduced to magnitudes up front and the signs are
// reapplied to the quotient and remainder in a final fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;

  // Operands captured on an accepted start; later input changes are ignored.
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic             signed_r;

  // Working registers of the restoring loop.
  logic             q_neg;
  logic             r_neg;
  logic             dbz;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] b_mag;
  logic [CW-1:0]    count;

  // Combinational helpers.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             divisor_zero;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   pr_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Magnitudes of the captured operands; the largest magnitude (|MIN| in
  // signed mode, all ones in unsigned mode) still fits in WIDTH bits.
  always_comb begin
    dvd_neg      = signed_r & dividend_r[WIDTH-1];
    dvs_neg      = signed_r & divisor_r[WIDTH-1];
    dvd_mag      = dvd_neg ? (~dividend_r + WIDTH'(1)) : dividend_r;
    dvs_mag      = dvs_neg ? (~divisor_r + WIDTH'(1)) : divisor_r;
    divisor_zero = (divisor_r == '0);
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  // The extra top bit keeps the trial sign correct for full-range unsigned divisors.
  always_comb begin
    shifted  = {pr, q_sh[WIDTH-1]};
    trial    = shifted - {2'b00, b_mag};
    trial_ok = ~trial[WIDTH+1];
    pr_step  = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

  // Sign fix-up; negating q=|MIN| wraps back to MIN, which is the overflow result.
  always_comb begin
    q_fix = q_neg ? (~q_sh + WIDTH'(1)) : q_sh;
    r_fix = r_neg ? (~pr[WIDTH-1:0] + WIDTH'(1)) : pr[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus busy and the start-accept strobe.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = PREP;
        end
      end
      PREP: begin
        busy      = 1'b1;
        state_nxt = divisor_zero ? FIX : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (count == '0) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and result registers; results hold until the next FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_r  <= '0;
      divisor_r   <= '0;
      signed_r    <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      pr          <= '0;
      q_sh        <= '0;
      b_mag       <= '0;
      count       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dividend_r  <= dividend;
            divisor_r   <= divisor;
            signed_r    <= signed_mode;
            div_by_zero <= 1'b0;
          end
        end
        PREP: begin
          q_neg <= dvd_neg ^ dvs_neg;
          r_neg <= dvd_neg;
          dbz   <= divisor_zero;
          pr    <= '0;
          q_sh  <= dvd_mag;
          b_mag <= dvs_mag;
          count <= CW'(WIDTH - 1);
        end
        ITER: begin
          pr   <= pr_step;
          q_sh <= {q_sh[WIDTH-2:0], trial_ok};
          if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (dbz) begin
            quotient    <= '1;
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with WIDTH=8.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           start_cycle;
    int           lat;
  } exp_t;

  exp_t sb[$];

  int check_count = 0;
  int pass_count  = 0;
  int cycle       = 0;
  int busy_run    = 0;
  bit prev_done   = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_mode(signed_mode),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference divider built on the simulator's integer arithmetic.
  function automatic void model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
    int ia;
    int ib;
    if (b == '0) begin
      q = '1;
      r = a;
      dbz = 1'b1;
    end else begin
      if (sm) begin
        ia = int'($signed(a));
        ib = int'($signed(b));
      end else begin
        ia = int'(a);
        ib = int'(b);
      end
      q = W'(ia / ib);
      r = W'(ia % ib);
      dbz = 1'b0;
    end
  endfunction

  // Drives one start pulse once the divider is idle; optionally queues the expected result.
  task automatic applyStimulus(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                               input bit expect_it, input string tag);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput({tag, ":idle_wait"}, busy, 0);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_it) begin
      e.tag         = tag;
      e.q           = eq;
      e.r           = er;
      e.dbz         = edbz;
      e.start_cycle = cycle;
      e.lat         = edbz ? 2 : W + 2;
      sb.push_back(e);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_results", sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every done and checks handshake rules.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) checkOutput("done_one_cycle", done, 0);
    if (done) begin
      checkOutput("busy_with_done", busy, 0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.tag, ":quotient"}, quotient, e.q);
        checkOutput({e.tag, ":remainder"}, remainder, e.r);
        checkOutput({e.tag, ":div_by_zero"}, div_by_zero, e.dbz);
        checkOutput({e.tag, ":latency"}, cycle - e.start_cycle, e.lat);
        checkOutput({e.tag, ":busy_cycles"}, busy_run, e.lat);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
    prev_done = done;
  end

  // Main stimulus sequence.
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    bit           sm;
    int           n;

    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset:busy", busy, 0);
    checkOutput("reset:done", done, 0);
    checkOutput("reset:quotient", quotient, 0);
    checkOutput("reset:remainder", remainder, 0);
    checkOutput("reset:div_by_zero", div_by_zero, 0);
    rst = 1'b0;

    applyStimulus(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1, "u200_7");
    waitIdle();
    applyStimulus(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b1, "s_m7_2");
    applyStimulus(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1, "s_7_m2");
    applyStimulus(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, "s_min_m1");
    applyStimulus(1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b1, "u_80_ff");
    applyStimulus(1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b1, "u_dbz");
    applyStimulus(1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b1, "s_dbz");
    waitIdle();

    applyStimulus(1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1, "u100_9");
    checkOutput("dbz_clear_on_start", div_by_zero, 0);
    checkOutput("quotient_held", quotient, 8'hFF);
    checkOutput("remainder_held", remainder, 8'h55);
    waitIdle();

    // Reset during the third ITER cycle; the interrupted result must vanish.
    applyStimulus(1'b0, 8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, "aborted");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst:busy", busy, 0);
    checkOutput("midrst:done", done, 0);
    checkOutput("midrst:quotient", quotient, 0);
    checkOutput("midrst:remainder", remainder, 0);
    checkOutput("midrst:div_by_zero", div_by_zero, 0);
    repeat (15) @(negedge clk);
    applyStimulus(1'b0, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1, "after_rst");
    waitIdle();

    // A start pulse with new operands while busy is ignored.
    applyStimulus(1'b0, 8'd250, 8'd3, 8'd83, 8'd1, 1'b0, 1'b1, "ignore_start");
    repeat (3) @(negedge clk);
    dividend = 8'd5;
    divisor = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Start held high through the done cycle launches the next operation at once.
    applyStimulus(1'b0, 8'd123, 8'd10, 8'd12, 8'd3, 1'b0, 1'b1, "b2b_first");
    signed_mode = 1'b1;
    dividend = 8'h9C;
    divisor = 8'h07;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    checkOutput("b2b:first_done_seen", done, 1);
    begin
      exp_t e;
      e.tag = "b2b_second";
      e.q = 8'hF2;
      e.r = 8'hFE;
      e.dbz = 1'b0;
      e.start_cycle = cycle + 1;
      e.lat = W + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    waitIdle();

    // Randomised operands in both modes, with an occasional zero divisor.
    for (int i = 0; i < 24; i++) begin
      sm = 1'($urandom_range(0, 1));
      a = W'($urandom_range(0, 255));
      b = (i % 7 == 3) ? '0 : W'($urandom_range(0, 255));
      model(sm, a, b, eq, er, edbz);
      applyStimulus(sm, a, b, eq, er, edbz, 1'b1, $sformatf("rand%0d", i));
    end
    waitIdle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
